stream_checker: RTL

- Parametrised successor to the single-word asserter: a stream-sink checker for the toolbox test suite.
- Consumes a stb/ack stream and compares each word against an expected sequence (constant or incrementing).
- Counts words and mismatches, and detects a stalled producer by timeout.
- Drives sticky done/pass/fail flags that a test harness polls or routes to a simulation stop.

---
 rtl/stream_checker.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stream_checker.sv
// stream_checker: stream-sink checker for the toolbox test suite.
//
// Consumes a stb/ack stream and compares every accepted word against an
// expected sequence. The sequence is either constant or advances by `step`
// after each word. The checker counts words and mismatches and flags a
// stalled producer through an idle timeout. Its sticky done/pass/fail flags
// can be polled by a harness.
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset; takes priority over clear
//   clear             synchronous restart to RUN with counters and flags zeroed
//   in1               stream data
//   in1_stb           producer data valid
//   in1_ack           checker accepts word (registered)
//   done              sticky: check finished
//   pass              sticky: finished with no mismatch and no timeout
//   fail              sticky: mismatch seen or timeout
//   timed_out         sticky: fail was caused by timeout
//   error_count       mismatches, saturating at 16'hFFFF
//   word_count        words accepted, wrapping
//   first_error_index word_count value at the first mismatch; 0 if none
module stream_checker #(
  parameter int unsigned     bits          = 16,
  parameter int unsigned     mode          = 0,
  parameter logic [bits-1:0] start_value   = '0,
  parameter logic [bits-1:0] step          = 1,
  parameter int unsigned     count         = 8,
  parameter int unsigned     timeout       = 1000,
  parameter bit              stop_on_error = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [bits-1:0] in1,
  input  logic            in1_stb,
  output logic            in1_ack,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timed_out,
  output logic [15:0]     error_count,
  output logic [15:0]     word_count,
  output logic [15:0]     first_error_index
);

  typedef enum logic [1:0] {StRun, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic [bits-1:0] expected_q, expected_d;
  logic [31:0]     idle_q, idle_d;
  logic            ack_q, ack_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            tout_q, tout_d;
  logic [15:0]     error_count_q, error_count_d;
  logic [15:0]     word_count_q, word_count_d;
  logic [15:0]     fei_q, fei_d;

  logic xfer;
  logic mismatch;
  logic finish;

  // ack_q is only ever high in RUN, so it alone qualifies a transfer.
  assign xfer     = ack_q & in1_stb;
  assign mismatch = xfer & (in1 != expected_q);

  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    idle_d        = idle_q;
    ack_d         = ack_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    tout_d        = tout_q;
    error_count_d = error_count_q;
    word_count_d  = word_count_q;
    fei_d         = fei_q;
    finish        = 1'b0;

    unique case (state_q)
      StRun: begin
        if (xfer) begin
          word_count_d = word_count_q + 16'd1;
          idle_d       = '0;
          if (mismatch) begin
            if (error_count_q != 16'hFFFF) begin
              error_count_d = error_count_q + 16'd1;
            end
            if (!fail_q) begin
              fail_d = 1'b1;
              fei_d  = word_count_q;
            end
          end
          if (mode == 1) begin
            expected_d = expected_q + step;
          end
          if ((count != 0 && 32'(word_count_d) == count) || (stop_on_error && mismatch)) begin
            finish = 1'b1;
          end else begin
            state_d = StGap;
            ack_d   = 1'b0;
          end
        end else if (ack_q) begin
          idle_d = idle_q + 32'd1;
          if (timeout != 0 && idle_d == timeout) begin
            fail_d = 1'b1;
            tout_d = 1'b1;
            finish = 1'b1;
          end
        end else begin
          // First cycle after reset: ack is still low, so start offering it.
          ack_d = 1'b1;
        end
      end
      StGap: begin
        state_d = StRun;
        ack_d   = 1'b1;
      end
      StDone: begin
        ack_d = 1'b0;
      end
      default: begin
        state_d = StRun;
        ack_d   = 1'b0;
      end
    endcase

    if (finish) begin
      state_d = StDone;
      ack_d   = 1'b0;
      done_d  = 1'b1;
      pass_d  = ~fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= StRun;
      expected_q    <= start_value;
      idle_q        <= '0;
      // After clear the checker is immediately ready; after rst every output starts at 0.
      ack_q         <= ~rst;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      tout_q        <= 1'b0;
      error_count_q <= '0;
      word_count_q  <= '0;
      fei_q         <= '0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      idle_q        <= idle_d;
      ack_q         <= ack_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      tout_q        <= tout_d;
      error_count_q <= error_count_d;
      word_count_q  <= word_count_d;
      fei_q         <= fei_d;
    end
  end

  assign in1_ack           = ack_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign fail              = fail_q;
  assign timed_out         = tout_q;
  assign error_count       = error_count_q;
  assign word_count        = word_count_q;
  assign first_error_index = fei_q;

endmodule
